bcd_down_counter: RTL and testbench



---
 rtl/bcd_down_counter_pkg.sv | 15 +
 rtl/bcd_down_counter_if.sv | 26 ++
 rtl/bcd_down_counter_digit_dec.sv | 33 +++
 rtl/bcd_down_counter.sv | 110 +++++++++++
 tb/tb_bcd_down_counter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bcd_down_counter_pkg.sv
// Shared constants for the BCD countdown counter: FSM encodings, BCD digit
// width/limit and a digit validity helper.
package bcd_down_counter_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD countdown counter; master drives the
// requests, slave (the counter) returns count and status pulses.
interface bcd_down_counter_if #(
  parameter int DIGITS = 4
);

  logic                  i_load;
  logic [4*DIGITS-1:0]   i_load_val;
  logic                  i_start;
  logic                  i_stop;
  logic [4*DIGITS-1:0]   o_cnt;
  logic                  o_running;
  logic                  o_done;
  logic                  o_err;

  modport master (
    output i_load, i_load_val, i_start, i_stop,
    input  o_cnt, o_running, o_done, o_err
  );

  modport slave (
    input  i_load, i_load_val, i_start, i_stop,
    output o_cnt, o_running, o_done, o_err
  );

endinterface

// File: rtl/bcd_down_counter_digit_dec.sv
// One BCD digit of the borrow chain; also flags whether the incoming digit
// is a legal BCD value so the same cell can screen load data.
module bcd_digit_dec
  import bcd_down_counter_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_borrow,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_borrow,
  output logic             o_valid
);

  // Decrement with borrow: a zero digit under borrow wraps to 9 and keeps borrowing
  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_borrow) begin
      if (i_digit == 4'd0) begin
        o_digit  = BCD_MAX;
        o_borrow = 1'b1;
      end else begin
        o_digit  = i_digit - 4'd1;
        o_borrow = 1'b0;
      end
    end else begin
      o_digit  = i_digit;
      o_borrow = 1'b0;
    end
  end

  assign o_valid = is_bcd(i_digit);

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD countdown counter with prescaled decrement,
// one-cycle done pulse on reaching zero and error pulse on non-BCD loads.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50
) (
  input  logic               clk,
  input  logic               rst,
  bcd_down_counter_if.slave  bus
);

  localparam int CW = BCD_W * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_ONE  = PW'(1);

  logic [0:0]    r_state;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_err;

  logic [CW-1:0] w_dec_cnt;
  logic [DIGITS:0] w_borrow;
  logic [DIGITS-1:0] w_dec_valid;
  logic [DIGITS-1:0] w_ld_valid;
  logic [DIGITS-1:0] w_ld_borrow;
  logic [CW-1:0] w_ld_pass;
  logic          w_ld_ok;
  logic          w_dec_zero;
  logic          w_unused;

  assign w_borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_dec u_dec (
        .i_digit  (r_cnt[g*BCD_W +: BCD_W]),
        .i_borrow (w_borrow[g]),
        .o_digit  (w_dec_cnt[g*BCD_W +: BCD_W]),
        .o_borrow (w_borrow[g+1]),
        .o_valid  (w_dec_valid[g])
      );
      bcd_digit_dec u_chk (
        .i_digit  (bus.i_load_val[g*BCD_W +: BCD_W]),
        .i_borrow (1'b0),
        .o_digit  (w_ld_pass[g*BCD_W +: BCD_W]),
        .o_borrow (w_ld_borrow[g]),
        .o_valid  (w_ld_valid[g])
      );
    end
  endgenerate

  assign w_ld_ok    = &w_ld_valid;
  assign w_dec_zero = (w_dec_cnt == {CW{1'b0}});
  assign w_unused   = &{w_borrow[DIGITS], w_dec_valid, w_ld_borrow};

  // FSM, prescaler and count; priority is load > stop > start > tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_presc <= {PW{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (bus.i_load) begin
        if (w_ld_ok) begin
          r_cnt   <= w_ld_pass;
          r_state <= ST_IDLE;
          r_presc <= {PW{1'b0}};
        end else begin
          r_err <= 1'b1;
        end
      end else if (bus.i_stop) begin
        if (r_state == ST_RUN) begin
          r_state <= ST_IDLE;
          r_presc <= {PW{1'b0}};
        end
      end else if (bus.i_start && (r_state == ST_IDLE)) begin
        if (r_cnt != {CW{1'b0}}) begin
          r_state <= ST_RUN;
          r_presc <= {PW{1'b0}};
        end
      end else if (r_state == ST_RUN) begin
        if (r_presc == PS_LAST) begin
          r_presc <= {PW{1'b0}};
          r_cnt   <= w_dec_cnt;
          if (w_dec_zero) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end else begin
          r_presc <= r_presc + PS_ONE;
        end
      end
    end
  end

  assign bus.o_cnt     = r_cnt;
  assign bus.o_running = (r_state == ST_RUN);
  assign bus.o_done    = r_done;
  assign bus.o_err     = r_err;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed scoreboard bench for bcd_down_counter with DIGITS=2, PRESCALE=3.
module tb_bcd_down_counter;

  logic clk;
  logic rst;

  bcd_down_counter_if #(.DIGITS(2)) bus ();

  bcd_down_counter #(.DIGITS(2), .PRESCALE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       run;
    logic       done;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic push(input string tag, input logic [7:0] cnt, input logic run,
                      input logic done, input logic err);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.run = run; e.done = done; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [10:0] obs;
    logic [10:0] req;
    e   = sb_q.pop_front();
    obs = {bus.o_cnt, bus.o_running, bus.o_done, bus.o_err};
    req = {e.cnt, e.run, e.done, e.err};
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: got cnt=%h run=%b done=%b err=%b, expected cnt=%h run=%b done=%b err=%b",
             e.tag, bus.o_cnt, bus.o_running, bus.o_done, bus.o_err, e.cnt, e.run, e.done, e.err);
    end
  endtask

  task automatic drive(input logic load, input logic [7:0] val, input logic start, input logic stop);
    bus.i_load = load; bus.i_load_val = val; bus.i_start = start; bus.i_stop = stop;
    @(posedge clk); #1;
    bus.i_load = 1'b0; bus.i_load_val = 8'h00; bus.i_start = 1'b0; bus.i_stop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.i_load = 1'b0; bus.i_load_val = 8'h00; bus.i_start = 1'b0; bus.i_stop = 1'b0;

    // 1. asynchronous reset while clock is low
    #2 rst = 1'b1;
    #1;
    push("reset_async", 8'h00, 1'b0, 1'b0, 1'b0); check();
    @(negedge clk); rst = 1'b0;

    // 2. full countdown from 12
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    push("load12", 8'h12, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("start12", 8'h12, 1'b1, 1'b0, 1'b0); check();
    for (int k = 1; k <= 37; k++) begin
      idle(1);
      if (k <= 36) push("countdown", to_bcd(12 - k / 3), (k < 36), (k == 36), 1'b0);
      else         push("done_clear", 8'h00, 1'b0, 1'b0, 1'b0);
      check();
    end

    // 3. borrow across digits, then start at zero is ignored
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    push("load10", 8'h10, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("start10", 8'h10, 1'b1, 1'b0, 1'b0); check();
    idle(2);
    push("pre_borrow", 8'h10, 1'b1, 1'b0, 1'b0); check();
    idle(1);
    push("borrow09", 8'h09, 1'b1, 1'b0, 1'b0); check();
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    push("load00_run", 8'h00, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("start_zero", 8'h00, 1'b0, 1'b0, 1'b0); check();
    idle(1);
    push("zero_no_done", 8'h00, 1'b0, 1'b0, 1'b0); check();

    // 4. invalid load is rejected with an error pulse
    drive(1'b1, 8'h25, 1'b0, 1'b0);
    push("load25", 8'h25, 1'b0, 1'b0, 1'b0); check();
    drive(1'b1, 8'h1A, 1'b0, 1'b0);
    push("bad_load", 8'h25, 1'b0, 1'b0, 1'b1); check();
    idle(1);
    push("err_clear", 8'h25, 1'b0, 1'b0, 1'b0); check();
    drive(1'b1, 8'hA3, 1'b0, 1'b0);
    push("bad_load_hi", 8'h25, 1'b0, 1'b0, 1'b1); check();

    // 5. pause/resume, start+stop, load on a tick edge
    drive(1'b1, 8'h09, 1'b0, 1'b0);
    push("load09", 8'h09, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("start09", 8'h09, 1'b1, 1'b0, 1'b0); check();
    idle(6);
    push("at07", 8'h07, 1'b1, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    push("stop07", 8'h07, 1'b0, 1'b0, 1'b0); check();
    idle(10);
    push("hold07", 8'h07, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("resume07", 8'h07, 1'b1, 1'b0, 1'b0); check();
    idle(2);
    push("resume_wait", 8'h07, 1'b1, 1'b0, 1'b0); check();
    idle(1);
    push("resume06", 8'h06, 1'b1, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    push("start_stop", 8'h06, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("restart06", 8'h06, 1'b1, 1'b0, 1'b0); check();
    idle(2);
    push("pre_tick", 8'h06, 1'b1, 1'b0, 1'b0); check();
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    push("load_on_tick", 8'h30, 1'b0, 1'b0, 1'b0); check();
    idle(1);
    push("load_tick_after", 8'h30, 1'b0, 1'b0, 1'b0); check();

    // 6. reset in the middle of a run
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    push("load06", 8'h06, 1'b0, 1'b0, 1'b0); check();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    push("start06", 8'h06, 1'b1, 1'b0, 1'b0); check();
    idle(3);
    push("at05", 8'h05, 1'b1, 1'b0, 1'b0); check();
    #2 rst = 1'b1;
    #1;
    push("reset_midrun", 8'h00, 1'b0, 1'b0, 1'b0); check();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      push("post_reset", 8'h00, 1'b0, 1'b0, 1'b0); check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
